calc_sequencer: RTL

Sequences a two-operand keyboard calculator: consumes released-key scancodes from the PS/2 protocol block, one single-cycle strobe per key. Collects operand A, then an operator, then operand B. Computes and holds a registered result for the 7-segment result decoder. Adds clear (Esc) and an inactivity timeout, so the datapath always sees a consistent A/op/B triple instead of a free-running scancode history.

---
 rtl/calc_pkg.sv | 58 +++++
 rtl/calc_key_decode.sv | 33 +++
 rtl/calc_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: scancodes, operators, FSM states,
// key classes, and the small ALU used to form a registered result.
package calc_pkg;

  localparam logic [7:0] KC_D0  = 8'h45;
  localparam logic [7:0] KC_D1  = 8'h16;
  localparam logic [7:0] KC_D2  = 8'h1E;
  localparam logic [7:0] KC_D3  = 8'h26;
  localparam logic [7:0] KC_D4  = 8'h25;
  localparam logic [7:0] KC_D5  = 8'h2E;
  localparam logic [7:0] KC_D6  = 8'h36;
  localparam logic [7:0] KC_D7  = 8'h3D;
  localparam logic [7:0] KC_D8  = 8'h3E;
  localparam logic [7:0] KC_D9  = 8'h46;
  localparam logic [7:0] KC_ADD = 8'h79;
  localparam logic [7:0] KC_SUB = 8'h7B;
  localparam logic [7:0] KC_MUL = 8'h22;
  localparam logic [7:0] KC_ESC = 8'h76;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_NONE = 2'd3;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_OP = 2'd1,
    WAIT_B  = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KEY_DIGIT   = 2'd0,
    KEY_OPER    = 2'd1,
    KEY_CLEAR   = 2'd2,
    KEY_INVALID = 2'd3
  } key_class_t;

  // Returns {neg, magnitude[6:0]}; widths are wide enough that nothing wraps.
  function automatic logic [7:0] alu(input logic [3:0] a, input logic [3:0] b,
                                     input logic [1:0] op);
    logic [7:0] prod;
    logic [6:0] sum;
    logic [3:0] diff;
    logic [7:0] res;
    prod = {4'd0, a} * {4'd0, b};
    sum  = {3'd0, a} + {3'd0, b};
    diff = (a >= b) ? (a - b) : (b - a);
    case (op)
      OP_ADD:  res = {1'b0, sum};
      OP_SUB:  res = {(a < b), 3'd0, diff};
      OP_MUL:  res = {1'b0, prod[6:0]};
      default: res = 8'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc_key_decode.sv
// Combinational scancode classifier: digits carry their value, operators carry
// their op encoding, everything else carries zero.
module calc_key_decode
  import calc_pkg::*;
(
  input  logic [7:0] key_code,
  output logic [1:0] key_class,
  output logic [3:0] value
);

  always_comb begin
    key_class = KEY_INVALID;
    value     = 4'd0;
    case (key_code)
      KC_D0:  begin key_class = KEY_DIGIT; value = 4'd0; end
      KC_D1:  begin key_class = KEY_DIGIT; value = 4'd1; end
      KC_D2:  begin key_class = KEY_DIGIT; value = 4'd2; end
      KC_D3:  begin key_class = KEY_DIGIT; value = 4'd3; end
      KC_D4:  begin key_class = KEY_DIGIT; value = 4'd4; end
      KC_D5:  begin key_class = KEY_DIGIT; value = 4'd5; end
      KC_D6:  begin key_class = KEY_DIGIT; value = 4'd6; end
      KC_D7:  begin key_class = KEY_DIGIT; value = 4'd7; end
      KC_D8:  begin key_class = KEY_DIGIT; value = 4'd8; end
      KC_D9:  begin key_class = KEY_DIGIT; value = 4'd9; end
      KC_ADD: begin key_class = KEY_OPER;  value = {2'b00, OP_ADD}; end
      KC_SUB: begin key_class = KEY_OPER;  value = {2'b00, OP_SUB}; end
      KC_MUL: begin key_class = KEY_OPER;  value = {2'b00, OP_MUL}; end
      KC_ESC: begin key_class = KEY_CLEAR; value = 4'd0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// Two-operand calculator sequencer: collects A, op, B from released-key strobes
// and holds a registered result; Esc or an idle timeout returns to reset values.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [1:0] op_sel,
  output logic [6:0] result,
  output logic       result_neg,
  output logic       result_valid,
  output logic [1:0] state,
  output logic       key_err,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_n;
  logic [3:0]       a_q, a_n, b_q, b_n;
  logic [1:0]       op_q, op_n;
  logic [6:0]       res_q, res_n;
  logic             neg_q, neg_n, rv_q, rv_n, err_q, err_n, to_q, to_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       kclass;
  logic [3:0]       kval;
  logic [7:0]       alu_out;

  calc_key_decode u_decode (
    .key_code  (key_code),
    .key_class (kclass),
    .value     (kval)
  );

  assign alu_out = alu(a_q, kval, op_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_A;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      op_q    <= OP_NONE;
      res_q   <= 7'd0;
      neg_q   <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      res_q   <= res_n;
      neg_q   <= neg_n;
      rv_q    <= rv_n;
      err_q   <= err_n;
      to_q    <= to_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    res_n   = res_q;
    neg_n   = neg_q;
    rv_n    = rv_q;
    err_n   = 1'b0;
    to_n    = 1'b0;
    cnt_n   = '0;
    if (key_valid) begin
      case (kclass)
        KEY_CLEAR: begin
          state_n = WAIT_A; a_n = 4'd0; b_n = 4'd0; op_n = OP_NONE;
          res_n = 7'd0; neg_n = 1'b0; rv_n = 1'b0;
        end
        KEY_INVALID: err_n = 1'b1;
        KEY_DIGIT: begin
          case (state_q)
            WAIT_A:  begin a_n = kval; state_n = WAIT_OP; end
            WAIT_OP: a_n = kval;
            WAIT_B: begin
              b_n = kval; res_n = alu_out[6:0]; neg_n = alu_out[7];
              rv_n = 1'b1; state_n = DONE;
            end
            default: begin
              a_n = kval; b_n = 4'd0; op_n = OP_NONE; rv_n = 1'b0;
              state_n = WAIT_OP;
            end
          endcase
        end
        default: begin
          case (state_q)
            WAIT_A: ;
            WAIT_OP: begin op_n = kval[1:0]; state_n = WAIT_B; end
            WAIT_B:  op_n = kval[1:0];
            default: begin
              // Chaining only carries a result that fits back into a single digit.
              if (res_q <= 7'd9 && !neg_q) a_n = res_q[3:0];
              else begin a_n = 4'd0; err_n = 1'b1; end
              op_n = kval[1:0]; rv_n = 1'b0; state_n = WAIT_B;
            end
          endcase
        end
      endcase
    end else if (state_q == WAIT_OP || state_q == WAIT_B) begin
      if (cnt_q == CNT_LAST) begin
        state_n = WAIT_A; a_n = 4'd0; b_n = 4'd0; op_n = OP_NONE;
        res_n = 7'd0; neg_n = 1'b0; rv_n = 1'b0; to_n = 1'b1;
      end else begin
        cnt_n = cnt_q + 1'b1;
      end
    end
  end

  assign op_a         = a_q;
  assign op_b         = b_q;
  assign op_sel       = op_q;
  assign result       = res_q;
  assign result_neg   = neg_q;
  assign result_valid = rv_q;
  assign state        = state_q;
  assign key_err      = err_q;
  assign timeout      = to_q;

endmodule
